lsq_multi_cdb: RTL and testbench

//   Parametrised in-order load/store queue that sits between dispatcher, ROB and memory controller.
//   It snoops NUM_CDB result buses plus its own result for operand wake-up.

---
 rtl/lsq_multi_cdb_if.sv | 51 +++++
 rtl/lsq_multi_cdb.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_lsq_multi_cdb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lsq_multi_cdb_if.sv
// Bundle of dispatcher, ROB, CDB and memory-controller signals around the load/store queue.
// The slave modport is the queue's view; the master modport is the environment driving it.
interface lsq_multi_cdb_if #(
  parameter int NUM_CDB = 2,
  parameter int ROBW    = 5
);
  logic                    rdy;
  logic                    rollback_signal;
  logic                    commit_valid;
  logic [ROBW-1:0]         commit_alias;
  logic [ROBW-1:0]         rob_head_alias;
  logic                    rdy_from_is;
  logic [2:0]              optype_from_is;
  logic [ROBW-1:0]         rd_alias_from_is;
  logic [ROBW-1:0]         Qi_from_is;
  logic [ROBW-1:0]         Qj_from_is;
  logic [31:0]             Vi_from_is;
  logic [31:0]             Vj_from_is;
  logic [31:0]             imm_from_is;
  logic                    lsb_full;
  logic                    ena_mc;
  logic                    wr_2mc;
  logic [31:0]             addr_2mc;
  logic [7:0]              data_2mc;
  logic                    rdy_from_mc;
  logic [7:0]              data_from_mc;
  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*ROBW-1:0] cdb_alias;
  logic [NUM_CDB*32-1:0]   cdb_data;
  logic                    lsb_has_result;
  logic [ROBW-1:0]         alias_from_lsb;
  logic [31:0]             result_from_lsb;

  modport slave (
    input  rdy, rollback_signal, commit_valid, commit_alias, rob_head_alias,
           rdy_from_is, optype_from_is, rd_alias_from_is, Qi_from_is, Qj_from_is,
           Vi_from_is, Vj_from_is, imm_from_is, rdy_from_mc, data_from_mc,
           cdb_valid, cdb_alias, cdb_data,
    output lsb_full, ena_mc, wr_2mc, addr_2mc, data_2mc,
           lsb_has_result, alias_from_lsb, result_from_lsb
  );

  modport master (
    output rdy, rollback_signal, commit_valid, commit_alias, rob_head_alias,
           rdy_from_is, optype_from_is, rd_alias_from_is, Qi_from_is, Qj_from_is,
           Vi_from_is, Vj_from_is, imm_from_is, rdy_from_mc, data_from_mc,
           cdb_valid, cdb_alias, cdb_data,
    input  lsb_full, ena_mc, wr_2mc, addr_2mc, data_2mc,
           lsb_has_result, alias_from_lsb, result_from_lsb
  );
endinterface

// File: rtl/lsq_multi_cdb.sv
// In-order load/store queue with CDB snooping, commit-gated stores, IO-load ordering and a
// byte-serial memory port.
//   state   | meaning
//   S_IDLE  | waiting for a ready head entry; pops it and starts the first byte
//   S_LOAD  | collecting load bytes from the memory controller
//   S_STORE | presenting store bytes; survives rollback with its pulse suppressed
module lsq_multi_cdb #(
  parameter int          ADDR_BITS = 4,
  parameter int          NUM_CDB   = 2,
  parameter logic [31:0] IO_BASE   = 32'h30000,
  parameter int          ROBW      = 5
) (
  input logic            clk,
  input logic            rst,
  lsq_multi_cdb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;
  localparam logic [ROBW-1:0] RENAMED_ZERO = '0;
  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  typedef struct packed {
    logic [2:0]      op;
    logic [ROBW-1:0] id;
    logic [ROBW-1:0] qi;
    logic [ROBW-1:0] qj;
    logic [31:0]     vi;
    logic [31:0]     vj;
    logic [31:0]     imm;
    logic            committed;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [2:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] op);
    case (op)
      OP_LB:   return {{24{v[7]}}, v[7:0]};
      OP_LH:   return {{16{v[15]}}, v[15:0]};
      OP_LBU:  return {24'd0, v[7:0]};
      OP_LHU:  return {16'd0, v[15:0]};
      OP_LW:   return v;
      default: return 32'd0;
    endcase
  endfunction

  entry_t               ent_q [DEPTH];
  entry_t               ent_d [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [ADDR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d, ncommit_q, ncommit_d;
  state_t               state_q, state_d;
  logic                 ena_q, ena_d, wr_q, wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [2:0]           nbytes_q, nbytes_d, idx_q, idx_d;
  logic [31:0]          ld_q, ld_d, st_q, st_d;
  logic [2:0]           op_q, op_d;
  logic [ROBW-1:0]      id_q, id_d;
  logic                 suppress_q, suppress_d;
  logic                 res_v_q, res_v_d;
  logic [ROBW-1:0]      res_id_q, res_id_d;
  logic [31:0]          res_q, res_d;

  // Snoop channels: external CDBs plus our own registered result pulse as the top channel.
  logic [NUM_CDB:0]           snp_v;
  logic [NUM_CDB:0][ROBW-1:0] snp_id;
  logic [NUM_CDB:0][31:0]     snp_data;
  assign snp_v    = {res_v_q, bus.cdb_valid};
  assign snp_id   = {res_id_q, bus.cdb_alias};
  assign snp_data = {res_q, bus.cdb_data};

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [ADDR_BITS-1:0] off;
    assign off      = ADDR_BITS'(g) - head_q;
    assign valid[g] = {1'b0, off} < count_q;
  end

  entry_t      hd;
  logic [31:0] head_addr;
  logic        head_ready, full, issue, pop;
  assign hd        = ent_q[head_q];
  assign head_addr = hd.vi + hd.imm;
  assign full      = count_q == CW'(DEPTH);
  assign head_ready = (count_q != '0) && (hd.qi == RENAMED_ZERO) && (hd.qj == RENAMED_ZERO) &&
                      (is_store(hd.op) ? hd.committed
                                       : ((head_addr < IO_BASE) || (hd.id == bus.rob_head_alias)));
  assign issue = bus.rdy_from_is && !full && !bus.rollback_signal;
  assign pop   = (state_q == S_IDLE) && head_ready && !bus.rollback_signal;

  entry_t      new_ent;
  logic        commit_hit;
  logic [31:0] ld_full;

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ncommit_d  = ncommit_q;
    state_d    = state_q;
    ena_d      = ena_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    idx_d      = idx_q;
    ld_d       = ld_q;
    st_d       = st_q;
    op_d       = op_q;
    id_d       = id_q;
    suppress_d = suppress_q;
    res_v_d    = 1'b0;
    res_id_d   = res_id_q;
    res_d      = res_q;
    commit_hit = 1'b0;
    ld_full    = ld_q;
    ld_full[{idx_q[1:0], 3'b000} +: 8] = bus.data_from_mc;

    new_ent = '{op: bus.optype_from_is, id: bus.rd_alias_from_is,
                qi: bus.Qi_from_is, qj: bus.Qj_from_is,
                vi: bus.Vi_from_is, vj: bus.Vj_from_is,
                imm: bus.imm_from_is, committed: 1'b0};

    for (int c = 0; c <= NUM_CDB; c++) begin
      if (snp_v[c] && bus.Qi_from_is != RENAMED_ZERO && bus.Qi_from_is == snp_id[c]) begin
        new_ent.qi = RENAMED_ZERO;
        new_ent.vi = snp_data[c];
      end
      if (snp_v[c] && bus.Qj_from_is != RENAMED_ZERO && bus.Qj_from_is == snp_id[c]) begin
        new_ent.qj = RENAMED_ZERO;
        new_ent.vj = snp_data[c];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        for (int c = 0; c <= NUM_CDB; c++) begin
          if (snp_v[c] && ent_q[i].qi != RENAMED_ZERO && ent_q[i].qi == snp_id[c]) begin
            ent_d[i].qi = RENAMED_ZERO;
            ent_d[i].vi = snp_data[c];
          end
          if (snp_v[c] && ent_q[i].qj != RENAMED_ZERO && ent_q[i].qj == snp_id[c]) begin
            ent_d[i].qj = RENAMED_ZERO;
            ent_d[i].vj = snp_data[c];
          end
        end
      end
    end

    if (bus.rollback_signal) begin
      count_d = ncommit_q;
      tail_d  = head_q + ncommit_q[ADDR_BITS-1:0];
    end else begin
      if (bus.commit_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && is_store(ent_q[i].op) && !ent_q[i].committed &&
              ent_q[i].id == bus.commit_alias) begin
            ent_d[i].committed = 1'b1;
            commit_hit         = 1'b1;
          end
        end
      end
      if (issue) begin
        ent_d[tail_q] = new_ent;
        tail_d        = tail_q + 1'b1;
      end
      count_d   = count_q + CW'(issue) - CW'(pop);
      ncommit_d = ncommit_q + CW'(commit_hit) - CW'(pop && is_store(hd.op));
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          head_d   = head_q + 1'b1;
          state_d  = is_store(hd.op) ? S_STORE : S_LOAD;
          ena_d    = 1'b1;
          wr_d     = is_store(hd.op);
          addr_d   = head_addr;
          data_d   = hd.vj[7:0];
          nbytes_d = op_bytes(hd.op);
          idx_d    = 3'd0;
          ld_d     = 32'd0;
          st_d     = hd.vj;
          op_d     = hd.op;
          id_d     = hd.id;
        end
      end
      S_LOAD: begin
        if (bus.rollback_signal) begin
          state_d = S_IDLE;
          ena_d   = 1'b0;
        end else if (bus.rdy_from_mc) begin
          ld_d = ld_full;
          if (idx_q == nbytes_q - 3'd1) begin
            state_d  = S_IDLE;
            ena_d    = 1'b0;
            res_v_d  = 1'b1;
            res_id_d = id_q;
            res_d    = extend(ld_full, op_q);
          end else begin
            addr_d = addr_q + 32'd1;
            idx_d  = idx_q + 3'd1;
          end
        end
      end
      S_STORE: begin
        suppress_d = suppress_q | bus.rollback_signal;
        if (bus.rdy_from_mc) begin
          if (idx_q == nbytes_q - 3'd1) begin
            state_d    = S_IDLE;
            ena_d      = 1'b0;
            suppress_d = 1'b0;
            if (!(suppress_q || bus.rollback_signal)) begin
              res_v_d  = 1'b1;
              res_id_d = id_q;
              res_d    = 32'd0;
            end
          end else begin
            addr_d = addr_q + 32'd1;
            idx_d  = idx_q + 3'd1;
            data_d = st_q[{idx_q[1:0] + 2'd1, 3'b000} +: 8];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ena_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ncommit_q  <= '0;
      state_q    <= S_IDLE;
      ena_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 8'd0;
      nbytes_q   <= 3'd0;
      idx_q      <= 3'd0;
      ld_q       <= 32'd0;
      st_q       <= 32'd0;
      op_q       <= 3'd0;
      id_q       <= '0;
      suppress_q <= 1'b0;
      res_v_q    <= 1'b0;
      res_id_q   <= '0;
      res_q      <= 32'd0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (bus.rdy) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ncommit_q  <= ncommit_d;
      state_q    <= state_d;
      ena_q      <= ena_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nbytes_q   <= nbytes_d;
      idx_q      <= idx_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      op_q       <= op_d;
      id_q       <= id_d;
      suppress_q <= suppress_d;
      res_v_q    <= res_v_d;
      res_id_q   <= res_id_d;
      res_q      <= res_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign bus.lsb_full        = full;
  assign bus.ena_mc          = ena_q;
  assign bus.wr_2mc          = wr_q;
  assign bus.addr_2mc        = addr_q;
  assign bus.data_2mc        = data_q;
  assign bus.lsb_has_result  = res_v_q;
  assign bus.alias_from_lsb  = res_id_q;
  assign bus.result_from_lsb = res_q;
endmodule

// File: tb/tb_lsq_multi_cdb.sv
// Directed bench for lsq_multi_cdb: byte-serial loads/stores, extension, commit gating,
// CDB bypass and wake-up, full queue, rollback and IO-load ordering.
module tb_lsq_multi_cdb;
  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_SB = 3'd5, OP_SW = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsq_multi_cdb_if #(.NUM_CDB(2), .ROBW(5)) bus ();

  lsq_multi_cdb #(.ADDR_BITS(4), .NUM_CDB(2), .IO_BASE(32'h30000), .ROBW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] id, input logic [4:0] qi,
                       input logic [4:0] qj, input logic [31:0] vi, input logic [31:0] vj,
                       input logic [31:0] imm);
    bus.optype_from_is   = op;
    bus.rd_alias_from_is = id;
    bus.Qi_from_is       = qi;
    bus.Qj_from_is       = qj;
    bus.Vi_from_is       = vi;
    bus.Vj_from_is       = vj;
    bus.imm_from_is      = imm;
    bus.rdy_from_is      = 1'b1;
    step();
    bus.rdy_from_is      = 1'b0;
  endtask

  task automatic commit(input logic [4:0] id);
    bus.commit_valid = 1'b1;
    bus.commit_alias = id;
    step();
    bus.commit_valid = 1'b0;
  endtask

  // Waits for the op to start, serves n byte handshakes and checks the single result pulse.
  task automatic mem_op(input string tag, input int n, input logic [31:0] a,
                        input logic [31:0] bytes, input logic st, input logic [4:0] id,
                        input logic [31:0] res);
    int t = 0;
    while (bus.ena_mc !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk({tag, "_ena"}, 32'(bus.ena_mc), 32'd1);
    chk({tag, "_wr"}, 32'(bus.wr_2mc), 32'(st));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_addr"}, bus.addr_2mc, a + 32'(k));
      if (st) chk({tag, "_wdata"}, 32'(bus.data_2mc), 32'(bytes[k*8 +: 8]));
      chk({tag, "_nopulse"}, 32'(bus.lsb_has_result), 32'd0);
      bus.data_from_mc = bytes[k*8 +: 8];
      bus.rdy_from_mc  = 1'b1;
      step();
    end
    bus.rdy_from_mc = 1'b0;
    chk({tag, "_ena_off"}, 32'(bus.ena_mc), 32'd0);
    chk({tag, "_pulse"}, 32'(bus.lsb_has_result), 32'd1);
    chk({tag, "_alias"}, 32'(bus.alias_from_lsb), 32'(id));
    chk({tag, "_result"}, bus.result_from_lsb, res);
    step();
    chk({tag, "_pulse_end"}, 32'(bus.lsb_has_result), 32'd0);
  endtask

  initial begin
    bus.rdy = 1'b1;             bus.rollback_signal = 1'b0;
    bus.commit_valid = 1'b0;    bus.commit_alias = '0;
    bus.rob_head_alias = '0;    bus.rdy_from_is = 1'b0;
    bus.optype_from_is = '0;    bus.rd_alias_from_is = '0;
    bus.Qi_from_is = '0;        bus.Qj_from_is = '0;
    bus.Vi_from_is = '0;        bus.Vj_from_is = '0;
    bus.imm_from_is = '0;       bus.rdy_from_mc = 1'b0;
    bus.data_from_mc = '0;      bus.cdb_valid = '0;
    bus.cdb_alias = '0;         bus.cdb_data = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ena", 32'(bus.ena_mc), 32'd0);
    chk("rst_wr", 32'(bus.wr_2mc), 32'd0);
    chk("rst_addr", bus.addr_2mc, 32'd0);
    chk("rst_data", 32'(bus.data_2mc), 32'd0);
    chk("rst_pulse", 32'(bus.lsb_has_result), 32'd0);
    chk("rst_alias", 32'(bus.alias_from_lsb), 32'd0);
    chk("rst_result", bus.result_from_lsb, 32'd0);
    chk("rst_full", 32'(bus.lsb_full), 32'd0);

    // LW and the extension variants
    issue(OP_LW, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4);
    mem_op("lw", 4, 32'h104, 32'h44332211, 1'b0, 5'd1, 32'h44332211);
    issue(OP_LB, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0, 32'h0);
    mem_op("lb", 1, 32'h200, 32'h00000080, 1'b0, 5'd2, 32'hFFFFFF80);
    issue(OP_LBU, 5'd3, 5'd0, 5'd0, 32'h200, 32'h0, 32'h0);
    mem_op("lbu", 1, 32'h200, 32'h00000080, 1'b0, 5'd3, 32'h00000080);
    issue(OP_LH, 5'd4, 5'd0, 5'd0, 32'h210, 32'h0, 32'h0);
    mem_op("lh", 2, 32'h210, 32'h00008000, 1'b0, 5'd4, 32'hFFFF8000);

    // SW held until the ROB commits it
    issue(OP_SW, 5'd5, 5'd0, 5'd0, 32'h300, 32'hA1B2C3D4, 32'h0);
    repeat (5) step();
    chk("sw_wait_commit", 32'(bus.ena_mc), 32'd0);
    commit(5'd5);
    mem_op("sw", 4, 32'h300, 32'hA1B2C3D4, 1'b1, 5'd5, 32'd0);

    // CDB channel 1 bypass into Vj on the issue cycle
    bus.cdb_valid = 2'b10;
    bus.cdb_alias = {5'd7, 5'd0};
    bus.cdb_data  = {32'h0000DEAD, 32'h0};
    issue(OP_SB, 5'd6, 5'd0, 5'd7, 32'h600, 32'h1111, 32'h0);
    bus.cdb_valid = 2'b00;
    commit(5'd6);
    mem_op("bypass_sb", 1, 32'h600, 32'h000000AD, 1'b1, 5'd6, 32'd0);

    // Later wake-up of Vi from CDB channel 0
    issue(OP_LW, 5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 32'h10);
    repeat (3) step();
    chk("wake_wait", 32'(bus.ena_mc), 32'd0);
    bus.cdb_valid = 2'b01;
    bus.cdb_alias = {5'd0, 5'd9};
    bus.cdb_data  = {32'h0, 32'h400};
    step();
    bus.cdb_valid = 2'b00;
    mem_op("wake_lw", 4, 32'h410, 32'hCAFEF00D, 1'b0, 5'd8, 32'hCAFEF00D);

    // Own result wakes a dependent load
    issue(OP_LB, 5'd10, 5'd0, 5'd0, 32'h500, 32'h0, 32'h0);
    issue(OP_LW, 5'd11, 5'd10, 5'd0, 32'h0, 32'h0, 32'h10);
    mem_op("own_lb", 1, 32'h500, 32'h00000040, 1'b0, 5'd10, 32'h40);
    mem_op("own_lw", 4, 32'h50, 32'h01020304, 1'b0, 5'd11, 32'h01020304);

    // Fill the queue behind an uncommitted store, then rollback
    issue(OP_SB, 5'd12, 5'd0, 5'd0, 32'h800, 32'h5A, 32'h0);
    issue(OP_SB, 5'd13, 5'd0, 5'd0, 32'h801, 32'hA5, 32'h0);
    for (int k = 0; k < 14; k++) issue(OP_LB, 5'(14 + k), 5'd0, 5'd0, 32'h900, 32'h0, 32'h0);
    chk("full_set", 32'(bus.lsb_full), 32'd1);
    issue(OP_LW, 5'd30, 5'd0, 5'd0, 32'h700, 32'h0, 32'h0);
    repeat (3) step();
    chk("full_issue_ignored", 32'(bus.ena_mc), 32'd0);
    chk("full_still", 32'(bus.lsb_full), 32'd1);
    commit(5'd12);
    commit(5'd13);
    step();
    chk("rb_st12_active", 32'(bus.ena_mc), 32'd1);
    chk("rb_st12_addr", bus.addr_2mc, 32'h800);
    bus.rollback_signal = 1'b1;
    step();
    bus.rollback_signal = 1'b0;
    chk("rb_not_full", 32'(bus.lsb_full), 32'd0);
    chk("rb_st12_continues", 32'(bus.ena_mc), 32'd1);
    bus.rdy_from_mc = 1'b1;
    step();
    bus.rdy_from_mc = 1'b0;
    chk("rb_st12_done", 32'(bus.ena_mc), 32'd0);
    chk("rb_st12_no_pulse", 32'(bus.lsb_has_result), 32'd0);
    mem_op("rb_st13", 1, 32'h801, 32'h000000A5, 1'b1, 5'd13, 32'd0);
    repeat (5) step();
    chk("rb_loads_gone", 32'(bus.ena_mc), 32'd0);

    // IO load waits for the ROB head
    bus.rob_head_alias = 5'd19;
    issue(OP_LW, 5'd20, 5'd0, 5'd0, 32'h30000, 32'h0, 32'h4);
    repeat (4) step();
    chk("io_blocked", 32'(bus.ena_mc), 32'd0);
    bus.rob_head_alias = 5'd20;
    step();
    chk("io_next_cycle", 32'(bus.ena_mc), 32'd1);
    mem_op("io_lw", 4, 32'h30004, 32'h12345678, 1'b0, 5'd20, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
